// File: rtl/vf_pkg.sv
// Shared definitions for the frame source: FSM state encoding and default fill byte.
package vf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        STREAM = 2'd2
    } vf_state_t;

    localparam logic [7:0] VF_FILL_BYTE = 8'h00;

endpackage

// File: rtl/vf_frame_source_sync_fifo.sv
// Single-clock FIFO with a first-word fall-through head and full/empty flags.
module sync_fifo #(
    parameter int W  = 9,
    parameter int AW = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Occupancy tops out at exactly 2**AW, so the MSB alone marks full.
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/vf_frame_source.sv
// Buffers producer pixel bytes and replays them, frame-aligned, to the USB camera core.
module vf_frame_source
    import vf_pkg::*;
#(
    parameter logic [13:0] FRAME_W   = 14'd252,
    parameter logic [13:0] FRAME_H   = 14'd120,
    parameter int          BPP       = 1,
    parameter int          FIFO_AW   = 10,
    parameter logic [7:0]  FILL_BYTE = VF_FILL_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic [7:0]  in_byte,
    input  logic        vf_sof,
    input  logic        vf_req,
    output logic [7:0]  vf_byte,
    output logic [15:0] frame_cnt,
    output logic [15:0] underrun_cnt
);

    localparam logic [31:0] FRAME_BYTES = 32'(FRAME_W) * 32'(FRAME_H) * 32'(BPP);

    vf_state_t   state;
    vf_state_t   state_n;
    logic [31:0] byte_cnt;
    logic [31:0] byte_cnt_n;
    logic [7:0]  vf_byte_n;
    logic [15:0] frame_cnt_n;
    logic [15:0] underrun_cnt_n;
    logic [15:0] underrun_inc;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [8:0]  head;
    logic        head_sof;
    logic [7:0]  head_byte;

    assign in_ready  = !fifo_full;
    assign head_sof  = head[8];
    assign head_byte = head[7:0];

    sync_fifo #(
        .W  (9),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid && in_ready),
        .wr_data ({in_sof, in_byte}),
        .rd_en   (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign underrun_inc = (underrun_cnt == 16'hFFFF) ? underrun_cnt : underrun_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            vf_byte      <= FILL_BYTE;
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            state        <= state_n;
            byte_cnt     <= byte_cnt_n;
            vf_byte      <= vf_byte_n;
            frame_cnt    <= frame_cnt_n;
            underrun_cnt <= underrun_cnt_n;
        end
    end

    always_comb begin
        state_n        = state;
        byte_cnt_n     = byte_cnt;
        vf_byte_n      = vf_byte;
        frame_cnt_n    = frame_cnt;
        underrun_cnt_n = underrun_cnt;
        fifo_pop       = 1'b0;

        if (vf_sof) begin
            state_n    = SYNC;
            byte_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vf_req) begin
                        vf_byte_n      = FILL_BYTE;
                        underrun_cnt_n = underrun_inc;
                    end
                end
                SYNC: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (head_sof) begin
                            vf_byte_n   = head_byte;
                            byte_cnt_n  = 32'd1;
                            state_n     = STREAM;
                            frame_cnt_n = frame_cnt + 16'd1;
                        end
                    end
                    // A request racing the sof pop still counts as an underrun,
                    // but the sof byte keeps the output register.
                    if (vf_req) begin
                        underrun_cnt_n = underrun_inc;
                        if (fifo_empty || !head_sof) begin
                            vf_byte_n = FILL_BYTE;
                        end
                    end
                end
                STREAM: begin
                    if (vf_req) begin
                        if (byte_cnt == FRAME_BYTES) begin
                            vf_byte_n = FILL_BYTE;
                        end else if (fifo_empty || head_sof) begin
                            vf_byte_n      = FILL_BYTE;
                            underrun_cnt_n = underrun_inc;
                        end else begin
                            vf_byte_n  = head_byte;
                            fifo_pop   = 1'b1;
                            byte_cnt_n = byte_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vf_frame_source.sv
// Checks vf_frame_source against a queue-based reference model plus directed frame sequences.
module tb_vf_frame_source;

    localparam int          DEPTH = 1024;
    localparam int unsigned FB    = 8;
    localparam logic [7:0]  FILL  = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [7:0]  in_byte;
    logic        vf_sof;
    logic        vf_req;
    logic [7:0]  vf_byte;
    logic [15:0] frame_cnt;
    logic [15:0] underrun_cnt;

    int total = 0;
    int bad   = 0;

    vf_frame_source #(
        .FRAME_W   (14'd4),
        .FRAME_H   (14'd2),
        .BPP       (1),
        .FIFO_AW   (10),
        .FILL_BYTE (8'h00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sof       (in_sof),
        .in_byte      (in_byte),
        .vf_sof       (vf_sof),
        .vf_req       (vf_req),
        .vf_byte      (vf_byte),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: buffered entries as a queue, phase 0 = waiting for vf_sof,
    // 1 = hunting for the sof entry, 2 = streaming a frame.
    typedef struct packed {
        logic       sof;
        logic [7:0] b;
    } ent_t;

    ent_t        q[$];
    int          phase;
    int unsigned m_cnt;
    logic [7:0]  m_byte;
    logic [15:0] m_frames;
    logic [15:0] m_under;

    function automatic void m_reset();
        q.delete();
        phase    = 0;
        m_cnt    = 0;
        m_byte   = FILL;
        m_frames = 16'd0;
        m_under  = 16'd0;
    endfunction

    function automatic void m_underrun();
        if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
    endfunction

    function automatic void m_step(input logic v, input logic s, input logic [7:0] b,
                                   input logic vs, input logic vr);
        bit push   = v && (q.size() < DEPTH);
        bit pop    = 1'b0;
        bit loaded = 1'b0;
        int was    = phase;
        if (vs) begin
            phase = 1;
            m_cnt = 0;
        end else begin
            if (was == 1 && q.size() > 0) begin
                pop = 1'b1;
                if (q[0].sof) begin
                    m_byte   = q[0].b;
                    loaded   = 1'b1;
                    m_cnt    = 1;
                    phase    = 2;
                    m_frames = m_frames + 16'd1;
                end
            end
            if (vr) begin
                if (was == 2) begin
                    if (m_cnt == FB) begin
                        m_byte = FILL;
                    end else if (q.size() > 0 && !q[0].sof) begin
                        m_byte = q[0].b;
                        pop    = 1'b1;
                        m_cnt++;
                    end else begin
                        m_byte = FILL;
                        m_underrun();
                    end
                end else begin
                    m_underrun();
                    if (!loaded) m_byte = FILL;
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{s, b});
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("vf_byte", 16'(vf_byte), 16'(m_byte));
        chk("frame_cnt", frame_cnt, m_frames);
        chk("underrun_cnt", underrun_cnt, m_under);
        chk("in_ready", 16'(in_ready), 16'(q.size() < DEPTH));
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] b,
                        input logic vs, input logic vr);
        in_valid = v;
        in_sof   = s;
        in_byte  = b;
        vf_sof   = vs;
        vf_req   = vr;
        @(posedge clk);
        m_step(v, s, b, vs, vr);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_all();
        in_valid = 1'b0;
        vf_sof   = 1'b0;
        vf_req   = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] first);
        for (int i = 0; i < 8; i++) step(1'b1, (i == 0), 8'(first + 8'(i)), 1'b0, 1'b0);
    endtask

    task automatic wait_frame(input logic [15:0] target, input int budget);
        int n = 0;
        while (frame_cnt != target && n < budget) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("sync_done", frame_cnt, target);
    endtask

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  b;
        logic        vs;
        logic        vr;
        logic [7:0]  eb;
        logic [15:0] ef;
        logic [15:0] eu;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rv;
        logic       rs;
        logic [7:0] rb;
        logic       rvs;
        logic       rvr;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_byte  = 8'h00;
        vf_sof   = 1'b0;
        vf_req   = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Nominal frame: 8 pushes, vf_sof, sync, 7 requests, then requests past frame end.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, (i == 0), 8'(8'h10 + i), 1'b0, 1'b0, 8'h00, 16'd0, 16'd0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'd0, 16'd0};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 16'd1, 16'd0};
        for (int i = 10; i < 17; i++)
            tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h11 + (i - 10)), 16'd1, 16'd0};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'd1, 16'd0};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'd1, 16'd0};
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].b, tbl[i].vs, tbl[i].vr);
            chk("tbl_byte", 16'(vf_byte), 16'(tbl[i].eb));
            chk("tbl_frames", frame_cnt, tbl[i].ef);
            chk("tbl_under", underrun_cnt, tbl[i].eu);
        end

        // Stale tail bytes ahead of a new frame are dropped during sync.
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b0);
        push_frame(8'h20);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_frame(16'd1, 10);
        chk("stale_first_byte", 16'(vf_byte), 16'h0020);

        // Sync on an empty FIFO: requests underrun until a frame arrives.
        async_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("empty_sync_byte", 16'(vf_byte), 16'h0000);
        chk("empty_sync_under", underrun_cnt, 16'd2);
        push_frame(8'h50);
        wait_frame(16'd1, 10);
        chk("late_frame_byte", 16'(vf_byte), 16'h0050);
        chk("late_frame_under", underrun_cnt, 16'd2);

        // Fill to full depth, attempt an overflow push, then free one slot.
        async_reset();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, (i == 0), (i == 0) ? 8'h40 : 8'(i), 1'b0, 1'b0);
        chk("full_ready", 16'(in_ready), 16'd0);
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'hEF, 1'b0, 1'b0);
        chk("ready_after_pop", 16'(in_ready), 16'd1);
        chk("full_sof_byte", 16'(vf_byte), 16'h0040);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("full_last_byte", 16'(vf_byte), 16'h0007);

        // Reset mid-frame: outputs clear at once and nothing buffered survives.
        async_reset();
        push_frame(8'h30);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_frame(16'd1, 10);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("pre_rst_byte", 16'(vf_byte), 16'h0033);
        async_reset();
        chk("rst_frames", frame_cnt, 16'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("post_rst_byte", 16'(vf_byte), 16'h0000);

        // Randomised traffic against the model.
        async_reset();
        for (int i = 0; i < 3000; i++) begin
            rv  = 1'($urandom_range(0, 1));
            rs  = ($urandom_range(0, 7) == 0);
            rb  = 8'($urandom);
            rvs = ($urandom_range(0, 40) == 0);
            rvr = 1'($urandom_range(0, 1));
            step(rv, rs, rb, rvs, rvr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
